rtl_kernel_1_multi_counter: RTL

Bank of C_NUM_CH independent up/down counters with per-channel load, programmable step, selectable wrap or saturate mode, zero/max flags and sticky overflow/underflow flags. It is the parametrised successor of the kernel's single example counter. It serves as the shared count/credit/length tracker inside generated RTL kernels, for example per-AXI-channel beat counters and outstanding-transaction credits.

---
 rtl/rtl_kernel_1_counter_pkg.sv | 32 +++
 rtl/rtl_kernel_1_counter_lane.sv | 84 ++++++++
 rtl/rtl_kernel_1_multi_counter.sv | 52 +++++
 3 files changed

// File: rtl/rtl_kernel_1_counter_pkg.sv
// Shared types and the per-channel operation decoder for the counter bank.
package rtl_kernel_1_counter_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_LOAD = 2'd1,
    CNT_INC  = 2'd2,
    CNT_DEC  = 2'd3
  } cnt_op_t;

  // Priority: load over a lone incr/decr; incr together with decr cancels out.
  function automatic cnt_op_t decode_op(
    input logic clken,
    input logic load,
    input logic incr,
    input logic decr
  );
    cnt_op_t op;
    op = CNT_HOLD;
    if (clken) begin
      if (load) begin
        op = CNT_LOAD;
      end else if (incr && !decr) begin
        op = CNT_INC;
      end else if (decr && !incr) begin
        op = CNT_DEC;
      end
    end
    return op;
  endfunction

endpackage

// File: rtl/rtl_kernel_1_counter_lane.sv
// One up/down counter channel with load, step, wrap/saturate and sticky flags.
// Latency 1 cycle, no backpressure; clken=0 freezes the whole lane.
module rtl_kernel_1_counter_lane
  import rtl_kernel_1_counter_pkg::*;
#(
  parameter int                 C_WIDTH      = 8,
  parameter int                 C_STEP_WIDTH = 4,
  parameter int                 C_SATURATE   = 0,
  parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    clken,
  input  logic                    load,
  input  logic [C_WIDTH-1:0]      load_value,
  input  logic                    incr,
  input  logic                    decr,
  input  logic [C_STEP_WIDTH-1:0] step,
  input  logic                    clr_flags,
  output logic [C_WIDTH-1:0]      count,
  output logic                    is_zero,
  output logic                    is_max,
  output logic                    ovf,
  output logic                    unf
);

  localparam logic [C_WIDTH-1:0] LP_MAX = {C_WIDTH{1'b1}};

  cnt_op_t            op;
  logic [C_WIDTH-1:0] step_ext;
  logic [C_WIDTH:0]   sum;
  logic [C_WIDTH:0]   diff;
  logic [C_WIDTH-1:0] next_count;
  logic               set_ovf;
  logic               set_unf;

  assign step_ext = C_WIDTH'(step);
  assign sum      = {1'b0, count} + {1'b0, step_ext};
  // Top bit of the extended subtraction is the borrow out.
  assign diff     = {1'b0, count} - {1'b0, step_ext};

  always_comb begin
    op         = decode_op(clken, load, incr, decr);
    next_count = count;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    case (op)
      CNT_LOAD: next_count = load_value;
      CNT_INC: begin
        next_count = sum[C_WIDTH-1:0];
        if (sum[C_WIDTH]) begin
          set_ovf = 1'b1;
          if (C_SATURATE != 0) next_count = LP_MAX;
        end
      end
      CNT_DEC: begin
        next_count = diff[C_WIDTH-1:0];
        if (diff[C_WIDTH]) begin
          set_unf = 1'b1;
          if (C_SATURATE != 0) next_count = '0;
        end
      end
      default: next_count = count;
    endcase
  end

  // Flags are derived from next_count so they line up with count each cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count   <= C_INIT;
      is_zero <= (C_INIT == '0);
      is_max  <= (C_INIT == LP_MAX);
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else if (clken) begin
      count   <= next_count;
      is_zero <= (next_count == '0);
      is_max  <= (next_count == LP_MAX);
      ovf     <= set_ovf | (ovf & ~clr_flags);
      unf     <= set_unf | (unf & ~clr_flags);
    end
  end

endmodule

// File: rtl/rtl_kernel_1_multi_counter.sv
// Bank of C_NUM_CH independent counter lanes behind packed buses.
// Latency 1 cycle, no backpressure; each channel has its own clock enable.
module rtl_kernel_1_multi_counter
  import rtl_kernel_1_counter_pkg::*;
#(
  parameter int                 C_NUM_CH     = 4,
  parameter int                 C_WIDTH      = 8,
  parameter int                 C_STEP_WIDTH = 4,
  parameter int                 C_SATURATE   = 0,
  parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [C_NUM_CH-1:0]              clken,
  input  logic [C_NUM_CH-1:0]              load,
  input  logic [C_NUM_CH*C_WIDTH-1:0]      load_value,
  input  logic [C_NUM_CH-1:0]              incr,
  input  logic [C_NUM_CH-1:0]              decr,
  input  logic [C_NUM_CH*C_STEP_WIDTH-1:0] step,
  input  logic [C_NUM_CH-1:0]              clr_flags,
  output logic [C_NUM_CH*C_WIDTH-1:0]      count,
  output logic [C_NUM_CH-1:0]              is_zero,
  output logic [C_NUM_CH-1:0]              is_max,
  output logic [C_NUM_CH-1:0]              ovf,
  output logic [C_NUM_CH-1:0]              unf
);

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_lane
    rtl_kernel_1_counter_lane #(
      .C_WIDTH      (C_WIDTH),
      .C_STEP_WIDTH (C_STEP_WIDTH),
      .C_SATURATE   (C_SATURATE),
      .C_INIT       (C_INIT)
    ) u_lane (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .clken      (clken[i]),
      .load       (load[i]),
      .load_value (load_value[i*C_WIDTH +: C_WIDTH]),
      .incr       (incr[i]),
      .decr       (decr[i]),
      .step       (step[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
      .clr_flags  (clr_flags[i]),
      .count      (count[i*C_WIDTH +: C_WIDTH]),
      .is_zero    (is_zero[i]),
      .is_max     (is_max[i]),
      .ovf        (ovf[i]),
      .unf        (unf[i])
    );
  end

endmodule
